// File: rtl/rgb2fbuf.sv
// rgb2fbuf: video capture endpoint.
// Locks onto the frame timing of an incoming parallel video stream and works
// out the vsync polarity by itself. It measures the active resolution of each
// frame and writes the active pixels into a framebuffer. Pixels are decimated
// by SCALING_FACTOR, so the stored layout matches the display-side reader.
module rgb2fbuf #(
    parameter int FRAME_H         = 640,
    parameter int FRAME_V         = 480,
    parameter int SCALING_FACTOR  = 1,
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int PIXEL_WIDTH     = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vde,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic [PIXEL_WIDTH-1:0]     pixel_data,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_wr_addr,
    output logic [PIXEL_WIDTH-1:0]     fbuf_wr_data,
    output logic                       fbuf_wr_en,
    output logic                       locked,
    output logic                       frame_done,
    output logic                       format_error,
    output logic [12:0]                h_active_measured,
    output logic [12:0]                v_active_measured
);

    // Decimation is restricted to powers of two, so division becomes a shift
    // and the modulo test becomes a mask on the low counter bits.
    localparam int          SHIFT      = (SCALING_FACTOR == 4) ? 2 :
                                         (SCALING_FACTOR == 2) ? 1 : 0;
    localparam int          LINE_WORDS = FRAME_H / SCALING_FACTOR;
    localparam logic [12:0] H_LIM      = 13'(FRAME_H);
    localparam logic [12:0] V_LIM      = 13'(FRAME_V);
    localparam logic [12:0] SUB_MASK   = 13'(SCALING_FACTOR - 1);
    localparam logic [12:0] CNT_MAX    = 13'h1FFF;

    typedef enum logic [1:0] {
        SEARCH      = 2'd0,
        WAIT_ACTIVE = 2'd1,
        CAPTURE     = 2'd2
    } state_t;

    state_t      state;

    // Timing trackers
    logic        vs_inactive;
    logic        vs_active;
    logic        vs_active_d;
    logic        vs_edge;
    logic        vde_d;
    logic        vde_rise;
    logic        vde_fall;

    // Frame geometry counters (all saturating)
    logic [12:0] x_cnt;
    logic [12:0] y_cnt;
    logic [12:0] first_len;
    logic        mismatch;

    // Frame-end summary, valid in the cycle a vs_edge closes a frame
    logic [12:0] cur_len;
    logic        line_open;
    logic [12:0] end_lines;
    logic [12:0] end_first_len;
    logic        end_mismatch;
    logic        end_ok;

    // Write qualification
    logic        capture_px;
    logic        wr_hit;
    logic [31:0] wr_addr_full;

    // hsync carries no information that the capture path needs.
    logic        unused_inputs;
    assign unused_inputs = hsync;

    function automatic logic [12:0] sat_inc(input logic [12:0] val);
        return (val == CNT_MAX) ? val : val + 13'd1;
    endfunction

    // Polarity is learned during active video. While vde=1 the vsync level
    // is by definition the inactive one. vs_active is therefore "differs
    // from that level", whichever polarity the source uses.
    assign vs_active = vsync ^ vs_inactive;
    assign vs_edge   = vs_active & ~vs_active_d;
    assign vde_rise  = vde & ~vde_d;
    assign vde_fall  = ~vde & vde_d;

    // Track the vsync inactive level and keep the previous-cycle copies for
    // edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            vs_inactive <= 1'b0;
            vs_active_d <= 1'b0;
            vde_d       <= 1'b0;
        end else begin
            if (vde) begin
                vs_inactive <= vsync;
            end
            vs_active_d <= vs_active;
            vde_d       <= vde;
        end
    end

    // Work out the frame result as if the current cycle ends the frame. A
    // line still open when vsync arrives counts as a line, and its pixel
    // count includes the pixel of this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        cur_len       = vde ? sat_inc(x_cnt) : x_cnt;
        line_open     = (cur_len != 13'd0);
        end_lines     = y_cnt;
        end_first_len = first_len;
        end_mismatch  = mismatch;
        if (line_open) begin
            end_lines = sat_inc(y_cnt);
            if (y_cnt == 13'd0) begin
                end_first_len = cur_len;
            end
            if (cur_len != H_LIM) begin
                end_mismatch = 1'b1;
            end
        end
        end_ok = !end_mismatch && (end_lines == V_LIM);
    end

    // Decide whether the pixel on the inputs goes into the framebuffer.
    // The first pixel of a frame is taken on the vde rise that leaves
    // WAIT_ACTIVE; the counters are already zero at that point. A frame-end
    // vsync edge overrides a coincident pixel.
    always_comb begin
        capture_px = ((state == CAPTURE) && vde && !vs_edge) ||
                     ((state == WAIT_ACTIVE) && vde_rise);
        wr_hit     = capture_px &&
                     (x_cnt < H_LIM) && (y_cnt < V_LIM) &&
                     ((x_cnt & SUB_MASK) == 13'd0) &&
                     ((y_cnt & SUB_MASK) == 13'd0);
        wr_addr_full = 32'(y_cnt >> SHIFT) * 32'(LINE_WORDS) +
                       32'(x_cnt >> SHIFT);
    end

    // Registered framebuffer write port. Address and data are forced to
    // zero whenever no write is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fbuf_wr_en   <= 1'b0;
            fbuf_wr_addr <= '0;
            fbuf_wr_data <= '0;
        end else begin
            fbuf_wr_en   <= wr_hit;
            fbuf_wr_addr <= wr_hit ? wr_addr_full[FBUF_ADDR_WIDTH-1:0] : '0;
            fbuf_wr_data <= wr_hit ? pixel_data : '0;
        end
    end

    // Capture state machine: frame locking, geometry counters and the
    // registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= SEARCH;
            x_cnt             <= 13'd0;
            y_cnt             <= 13'd0;
            first_len         <= 13'd0;
            mismatch          <= 1'b0;
            frame_done        <= 1'b0;
            locked            <= 1'b0;
            format_error      <= 1'b0;
            h_active_measured <= 13'd0;
            v_active_measured <= 13'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                SEARCH: begin
                    // Active video seen before any vsync is ignored here.
                    if (vs_edge) begin
                        state     <= WAIT_ACTIVE;
                        x_cnt     <= 13'd0;
                        y_cnt     <= 13'd0;
                        first_len <= 13'd0;
                        mismatch  <= 1'b0;
                    end
                end

                WAIT_ACTIVE: begin
                    // Pixel 0 of line 0 is consumed in this cycle.
                    if (vde_rise) begin
                        state <= CAPTURE;
                        x_cnt <= 13'd1;
                        y_cnt <= 13'd0;
                    end
                end

                CAPTURE: begin
                    if (vs_edge) begin
                        // Frame end. The same edge arms the next frame, so
                        // back-to-back frames are all captured.
                        frame_done        <= 1'b1;
                        locked            <= end_ok;
                        format_error      <= !end_ok;
                        h_active_measured <= end_first_len;
                        v_active_measured <= end_lines;
                        state             <= WAIT_ACTIVE;
                        x_cnt             <= 13'd0;
                        y_cnt             <= 13'd0;
                        first_len         <= 13'd0;
                        mismatch          <= 1'b0;
                    end else if (vde) begin
                        x_cnt <= sat_inc(x_cnt);
                    end else if (vde_fall) begin
                        // Line closed: x holds its length.
                        if (y_cnt == 13'd0) begin
                            first_len <= x_cnt;
                        end
                        if (x_cnt != H_LIM) begin
                            mismatch <= 1'b1;
                        end
                        y_cnt <= sat_inc(y_cnt);
                        x_cnt <= 13'd0;
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule
